// File: rtl/v_alu_arb2_pkg.sv
// v_alu_arb2_pkg: ALU op codes, arbiter requester ids and flag bit positions.
package v_alu_arb2_pkg;
  typedef logic [3:0] alu_op_t;
  localparam alu_op_t ALU_ADD  = 4'h0;
  localparam alu_op_t ALU_SUB  = 4'h1;
  localparam alu_op_t ALU_AND  = 4'h2;
  localparam alu_op_t ALU_OR   = 4'h3;
  localparam alu_op_t ALU_XOR  = 4'h4;
  localparam alu_op_t ALU_SLL  = 4'h5;
  localparam alu_op_t ALU_SRL  = 4'h6;
  localparam alu_op_t ALU_SRA  = 4'h7;
  localparam alu_op_t ALU_SLT  = 4'h8;
  localparam alu_op_t ALU_SLTU = 4'h9;
  localparam logic ARB_ID_REQ0 = 1'b0;
  localparam logic ARB_ID_REQ1 = 1'b1;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/v_alu_arb2_if.sv
// v_alu_arb2_if: two request channels and one result channel of the shared-ALU arbiter.
interface v_alu_arb2_if;
  logic                     req0_valid;
  logic                     req0_ready;
  logic [31:0]              req0_a;
  logic [31:0]              req0_b;
  v_alu_arb2_pkg::alu_op_t  req0_op;
  logic                     req1_valid;
  logic                     req1_ready;
  logic [31:0]              req1_a;
  logic [31:0]              req1_b;
  v_alu_arb2_pkg::alu_op_t  req1_op;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_result;
  logic [3:0]               out_flags;
  logic                     out_id;
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output out_ready,
    input  req0_ready, req1_ready, out_valid, out_result, out_flags, out_id
  );
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  out_ready,
    output req0_ready, req1_ready, out_valid, out_result, out_flags, out_id
  );
endinterface

// File: rtl/v_alu.sv
// v_alu: combinational 32-bit ALU with {Z,N,C,V} flags; undefined ops give 0.
module v_alu
  import v_alu_arb2_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] result,
  output logic [3:0]  flags
);
  logic [32:0] sum;
  logic [32:0] dif;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} + {1'b0, ~b} + 33'd1;
  always_comb begin
    result = '0;
    flags  = '0;
    case (op)
      ALU_ADD: begin
        result         = sum[31:0];
        flags[FLAG_C]  = sum[32];
        flags[FLAG_V]  = (a[31] == b[31]) & (sum[31] != a[31]);
      end
      ALU_SUB: begin
        result         = dif[31:0];
        flags[FLAG_C]  = dif[32];
        flags[FLAG_V]  = (a[31] != b[31]) & (dif[31] != a[31]);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $signed(a) >>> b[4:0];
      ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'd0, a < b};
      default:  result = '0;
    endcase
    flags[FLAG_Z] = result == '0;
    flags[FLAG_N] = result[31];
  end
endmodule

// File: rtl/v_alu_arb2.sv
// v_alu_arb2: round-robin arbiter sharing one v_alu between two requesters, registered result.
// Optional perf counters (perf_grant0/1, perf_conflict) when V_ALU_ARB_PERF_EN is defined.
module v_alu_arb2
  import v_alu_arb2_pkg::*;
#(
`ifdef V_ALU_ARB_PERF_EN
  parameter int   CNT_W     = 16,
`endif
  parameter logic RESET_PTR = 1'b0
) (
  input logic         clk,
  input logic         rst,
  v_alu_arb2_if.slave bus
`ifdef V_ALU_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_grant0,
  output logic [CNT_W-1:0] perf_grant1,
  output logic [CNT_W-1:0] perf_conflict
`endif
);
  logic        ptr;
  logic        both;
  logic        gnt;
  logic        can_accept;
  logic        xfer;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  alu_op_t     alu_op;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  assign both           = bus.req0_valid & bus.req1_valid;
  assign gnt            = both ? ptr : bus.req1_valid;
  assign can_accept     = !bus.out_valid | bus.out_ready;
  assign bus.req0_ready = !rst & can_accept & bus.req0_valid & (gnt == ARB_ID_REQ0);
  assign bus.req1_ready = !rst & can_accept & bus.req1_valid & (gnt == ARB_ID_REQ1);
  assign xfer           = bus.req0_ready | bus.req1_ready;
  assign alu_a          = gnt ? bus.req1_a  : bus.req0_a;
  assign alu_b          = gnt ? bus.req1_b  : bus.req0_b;
  assign alu_op         = gnt ? bus.req1_op : bus.req0_op;
  v_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .flags  (alu_flags)
  );
  // Data registers only move on a transfer; a plain drain just clears valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_flags  <= '0;
      bus.out_id     <= 1'b0;
      ptr            <= RESET_PTR;
    end else if (xfer) begin
      bus.out_valid  <= 1'b1;
      bus.out_result <= alu_result;
      bus.out_flags  <= alu_flags;
      bus.out_id     <= gnt;
      ptr            <= ~gnt;
    end else if (bus.out_ready) begin
      bus.out_valid  <= 1'b0;
    end
  end
`ifdef V_ALU_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant0   <= '0;
      perf_grant1   <= '0;
      perf_conflict <= '0;
    end else begin
      if (bus.req0_ready) perf_grant0 <= perf_grant0 + CNT_W'(1);
      if (bus.req1_ready) perf_grant1 <= perf_grant1 + CNT_W'(1);
      if (both & xfer) perf_conflict <= perf_conflict + CNT_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_v_alu_arb2.sv
// tb_v_alu_arb2: scoreboard bench for v_alu_arb2 with directed cases and random traffic.
module tb_v_alu_arb2;
  import v_alu_arb2_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  v_alu_arb2_if bus();
`ifdef V_ALU_ARB_PERF_EN
  logic [1:0] perf_grant0;
  logic [1:0] perf_grant1;
  logic [1:0] perf_conflict;
  v_alu_arb2 #(.CNT_W(2), .RESET_PTR(1'b0)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_conflict(perf_conflict)
  );
`else
  v_alu_arb2 #(.RESET_PTR(1'b0)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r;
    logic [3:0]  f;
    logic        id;
  } exp_t;
  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        pv[2];
  logic [31:0] pa[2];
  logic [31:0] pb[2];
  logic [3:0]  pop[2];
  logic        mv;
  logic        turn;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference ALU in wide integer arithmetic; returns {result, Z, N, C, V}.
  function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    longint      sa, sb, s;
    logic [31:0] r;
    logic        c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; c = 1'b0; v = 1'b0; s = 0;
    case (op)
      ALU_ADD: begin
        r = a + b;
        c = (longint'(a) + longint'(b)) >= 64'sd4294967296;
        s = sa + sb;
        v = s > 64'sd2147483647 || s < -64'sd2147483648;
      end
      ALU_SUB: begin
        r = a - b;
        c = a >= b;
        s = sa - sb;
        v = s > 64'sd2147483647 || s < -64'sd2147483648;
      end
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $signed(a) >>> b[4:0];
      ALU_SLT:  r = {31'd0, sa < sb};
      ALU_SLTU: r = {31'd0, a < b};
      default:  r = '0;
    endcase
    return {r, r == 32'd0, r[31], c, v};
  endfunction

  task automatic load(input int n, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    pv[n] = 1'b1; pa[n] = a; pb[n] = b; pop[n] = op;
  endtask

  // One cycle: drive pending requests, predict who is accepted, check readies, push expectation.
  task automatic step(input logic o_rdy);
    logic can, both;
    int   w;
    @(negedge clk);
    bus.req0_valid = pv[0]; bus.req0_a = pa[0]; bus.req0_b = pb[0]; bus.req0_op = pop[0];
    bus.req1_valid = pv[1]; bus.req1_a = pa[1]; bus.req1_b = pb[1]; bus.req1_op = pop[1];
    bus.out_ready  = o_rdy;
    #1;
    check("out_valid", bus.out_valid, mv);
    can  = !mv || o_rdy;
    both = pv[0] && pv[1];
    w    = both ? int'(turn) : (pv[1] ? 1 : 0);
    if (!(can && (pv[0] || pv[1]))) w = -1;
    check("req0_ready", bus.req0_ready, w == 0);
    check("req1_ready", bus.req1_ready, w == 1);
    if (w >= 0) begin
      q.push_back(exp_t'({ref_alu(pa[w], pb[w], pop[w]), w[0]}));
      pv[w] = 1'b0;
      turn  = ~w[0];
      mv    = 1'b1;
    end else if (o_rdy) begin
      mv = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_result", bus.out_result, 32'd0);
    check("rst_out_flags", bus.out_flags, 4'd0);
    check("rst_out_id", bus.out_id, 1'b0);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    check("rst_req0_ready", bus.req0_ready, 1'b0);
    check("rst_req1_ready", bus.req1_ready, 1'b0);
    rst = 1'b0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    q.delete();
    mv = 1'b0; turn = 1'b0; pv[0] = 1'b0; pv[1] = 1'b0;
  endtask

  task automatic check_out(input string name, input logic [31:0] r, input logic [3:0] f, input logic id);
    check({name, "_valid"}, bus.out_valid, 1'b1);
    check({name, "_result"}, bus.out_result, r);
    check({name, "_flags"}, bus.out_flags, f);
    check({name, "_id"}, bus.out_id, id);
  endtask

  // Monitor: compare each result when the consumer takes it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", 1'b1, 1'b0);
        end else begin
          e = q.pop_front();
          check("sb_result", bus.out_result, e.r);
          check("sb_flags", bus.out_flags, e.f);
          check("sb_id", bus.out_id, e.id);
        end
      end
    end
  end

  initial begin
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.out_ready = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    pa = '{32'd0, 32'd0}; pb = '{32'd0, 32'd0}; pop = '{4'd0, 4'd0};
    do_reset();
    load(0, 32'd5, 32'd3, ALU_ADD);
    step(1'b1);
    step(1'b1);
    check_out("add", 32'd8, 4'b0000, 1'b0);
    do_reset();
    load(0, 32'd3, 32'd5, ALU_SUB);
    load(1, 32'hF0F0_F0F0, 32'hFF00_FF00, ALU_AND);
    step(1'b1);
    step(1'b1);
    check_out("sub", 32'hFFFF_FFFE, 4'b0100, 1'b0);
    step(1'b1);
    check_out("and", 32'hF000_F000, 4'b0100, 1'b1);
    load(0, 32'h7FFF_FFFF, 32'd1, ALU_ADD);
    step(1'b1);
    load(1, 32'd1, 32'd2, ALU_XOR);
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      check_out("hold", 32'h8000_0000, 4'b0101, 1'b0);
    end
    step(1'b1);
    step(1'b1);
    check_out("drain_xfer", 32'd3, 4'b0000, 1'b1);
    load(1, 32'd1, 32'd31, ALU_SLL);
    step(1'b1);
    load(1, 32'h8000_0000, 32'd4, ALU_SRA);
    step(1'b1);
    check_out("sll", 32'h8000_0000, 4'b0100, 1'b1);
    step(1'b1);
    check_out("sra", 32'hF800_0000, 4'b0100, 1'b1);
    load(0, 32'h1234_5678, 32'h9ABC_DEF0, 4'hF);
    step(1'b1);
    step(1'b0);
    check_out("badop", 32'd0, 4'b1000, 1'b0);
    do_reset();
    load(0, 32'd10, 32'd20, ALU_SLT);
    load(1, 32'd10, 32'd20, ALU_SLTU);
    step(1'b1);
    for (int i = 0; i < 600; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pv[n] && $urandom_range(0, 9) < 7)
          load(n, $urandom, ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom,
               4'($urandom_range(0, 15)));
      end
      step($urandom_range(0, 3) != 0);
    end
    pv[0] = 1'b0; pv[1] = 1'b0;
    repeat (3) step(1'b1);
    check("queue_empty", q.size(), 0);
`ifdef V_ALU_ARB_PERF_EN
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (!pv[0]) load(0, 32'(i), 32'd1, ALU_ADD);
      if (!pv[1]) load(1, 32'(i), 32'd1, ALU_SUB);
      step(1'b1);
    end
    pv[0] = 1'b0; pv[1] = 1'b0;
    step(1'b1);
    check("perf_grant0", perf_grant0, 2'd3);
    check("perf_grant1", perf_grant1, 2'd2);
    check("perf_conflict", perf_conflict, 2'd1);
    repeat (2) step(1'b1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
